slv_guard_recovery_ctrl: RTL and testbench
==========================================

SLV_GUARD_RECOVERY_CTRL -- requirements
Module: slv_guard_recovery_ctrl

Interface
REQ-001 SHALL have parameter RstHoldCycles, default 16: cycles slv_rst_o is held asserted; legal range 1..65535.
REQ-002 SHALL have parameter AckTimeout, default 1024: maximum WAIT_ACK cycles before timeout; legal range 1..65535.
REQ-003 SHALL have parameter MaxRetries, default 3: reset re-assertions allowed after a timeout; legal range 1..15.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port rst_req_i, input, 1 bit: reset request from the write/read guard (level).
REQ-008 SHALL have port rst_stat_i, input, 1 bit: slave reset-complete status (level).
REQ-009 SHALL have port guard_ena_i, input, 1 bit: software enable for monitoring.
REQ-010 SHALL have port guard_ena_o, output, 1 bit: enable forwarded to the guard.
REQ-011 SHALL have port isolate_o, output, 1 bit: blocks AXI traffic to and from the slave.
REQ-012 SHALL have port slv_rst_o, output, 1 bit: active-high reset to the slave.
REQ-013 SHALL have port reset_clear_o, output, 1 bit: single-cycle pulse to the guard reset_clear_i.
REQ-014 SHALL have port fail_o, output, 1 bit: sticky recovery failure.
REQ-015 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-016 SHALL have port retry_cnt_o, output, 4 bits: retries consumed in the current recovery.

Function
REQ-017 SHALL implement FSM states IDLE=0, ISOLATE=1, ASSERT=2, WAIT_ACK=3, CLEAR=4, FAIL=5.
REQ-018 SHALL, in IDLE, drive guard_ena_o=guard_ena_i and isolate_o=0, and move to ISOLATE on rst_req_i=1.
REQ-019 SHALL, in ISOLATE, drive isolate_o=1 and guard_ena_o=0 for exactly 1 cycle, then move to ASSERT.
REQ-020 SHALL, in ASSERT, drive slv_rst_o=1 for exactly RstHoldCycles cycles, then move to WAIT_ACK.
REQ-021 SHALL, in WAIT_ACK, drive slv_rst_o=0 and move to CLEAR on rst_stat_i=1; on the AckTimeout-th cycle without rst_stat_i it SHALL time out (see REQ-033/034).
REQ-022 SHALL treat rst_stat_i=1 on the same cycle as the timeout as success.
REQ-023 SHALL, in CLEAR, pulse reset_clear_o for exactly the first cycle, hold isolate_o=1, and return to IDLE on the first cycle with rst_req_i=0 and rst_stat_i=1.
REQ-024 SHALL hold isolate_o=1 in every state except IDLE, and guard_ena_o=0 in every state except IDLE.
REQ-025 SHALL, in FAIL, hold isolate_o=1, slv_rst_o=0 and fail_o=1 until rst_i; FAIL has no other exit.
REQ-026 SHALL ignore rst_req_i in every state other than IDLE and CLEAR.
REQ-027 SHALL clear retry_cnt_o on entry to ISOLATE.
REQ-028 SHALL use one shared down-counter for hold and timeout, reloaded on each ASSERT and WAIT_ACK entry; its width SHALL be 16 bits with no wrap.

Reset
REQ-029 SHALL, while rst_i=1 on a clock edge, enter IDLE and force isolate_o=0, slv_rst_o=0, reset_clear_o=0, fail_o=0, retry_cnt_o=0 and counter=0.
REQ-030 SHALL let rst_i override any state, including mid-ASSERT; slv_rst_o SHALL deassert on the following cycle.
REQ-031 SHALL drive guard_ena_o=guard_ena_i while in reset.

Configuration
REQ-032 SHALL support the macro SLV_GUARD_RECOVERY_RETRY_EN.
REQ-033 SHALL, with SLV_GUARD_RECOVERY_RETRY_EN defined, return a timeout in WAIT_ACK to ASSERT and increment retry_cnt_o while retry_cnt_o<MaxRetries, otherwise go to FAIL.
REQ-034 SHALL, with SLV_GUARD_RECOVERY_RETRY_EN undefined, go directly from a timeout to FAIL, tie retry_cnt_o to 0 and omit the retry logic.

Structure
REQ-035 SHALL place the state enum (3 bits), the counter width constant (16) and the retry width constant (4) in the package slv_guard_recovery_pkg.
REQ-036 SHALL instantiate one sub-module, slv_guard_recovery_timer: a loadable 16-bit down-counter with load, enable, value and zero outputs.

Verification
REQ-037 SHALL cover nominal recovery: RstHoldCycles=4; rst_req_i=1 in IDLE, rst_stat_i=1 two cycles into WAIT_ACK -> ISOLATE 1 cycle, slv_rst_o high 4 cycles, one reset_clear_o pulse, IDLE after rst_req_i drops.
REQ-038 SHALL cover retry: RETRY_EN defined, AckTimeout=8, MaxRetries=2, rst_stat_i held at 0 -> ASSERT entered 3 times, retry_cnt_o=2, then FAIL with fail_o=1.
REQ-039 SHALL cover no-retry: RETRY_EN undefined, AckTimeout=8, rst_stat_i held at 0 -> FAIL 8 cycles after WAIT_ACK entry, retry_cnt_o=0.
REQ-040 SHALL cover the simultaneous edge: rst_stat_i rises on the timeout cycle -> CLEAR, not ASSERT or FAIL.
REQ-041 SHALL cover reset mid-ASSERT: rst_i pulsed on the 2nd hold cycle -> IDLE next cycle, slv_rst_o=0, isolate_o=0, fail_o=0.

Source files
------------

// File: rtl/slv_guard_recovery_pkg.sv
// Shared types and widths for the slave guard recovery controller.
package slv_guard_recovery_pkg;

  localparam int CNT_W   = 16;
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISOLATE  = 3'd1,
    ST_ASSERT   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_FAIL     = 3'd5
  } state_e;

endpackage

// File: rtl/slv_guard_recovery_if.sv
// Guard-side and slave-side signals of the recovery controller.
interface slv_guard_recovery_if;
  import slv_guard_recovery_pkg::*;

  logic               rst_req_i;
  logic               rst_stat_i;
  logic               guard_ena_i;
  logic               guard_ena_o;
  logic               isolate_o;
  logic               slv_rst_o;
  logic               reset_clear_o;
  logic               fail_o;
  logic [2:0]         state_o;
  logic [RETRY_W-1:0] retry_cnt_o;

  modport slave (
    input  rst_req_i, rst_stat_i, guard_ena_i,
    output guard_ena_o, isolate_o, slv_rst_o, reset_clear_o, fail_o, state_o, retry_cnt_o
  );

  modport master (
    output rst_req_i, rst_stat_i, guard_ena_i,
    input  guard_ena_o, isolate_o, slv_rst_o, reset_clear_o, fail_o, state_o, retry_cnt_o
  );
endinterface

// File: rtl/slv_guard_recovery_timer.sv
// Loadable down-counter shared by the reset hold and ack timeout phases.
module slv_guard_recovery_timer
  import slv_guard_recovery_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at zero so a late enable never wraps into a long timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/slv_guard_recovery_ctrl.sv
// Isolate / reset / acknowledge sequencer for a hung AXI slave.
// Optional bounded retry after ack timeout: define SLV_GUARD_RECOVERY_RETRY_EN.
module slv_guard_recovery_ctrl
  import slv_guard_recovery_pkg::*;
#(
  parameter int RstHoldCycles = 16,
  parameter int AckTimeout    = 1024,
  parameter int MaxRetries    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  slv_guard_recovery_if.slave  bus
);

  if (RstHoldCycles < 1 || RstHoldCycles > 65535) begin : g_bad_hold
    $error("RstHoldCycles out of range 1..65535");
  end
  if (AckTimeout < 1 || AckTimeout > 65535) begin : g_bad_timeout
    $error("AckTimeout out of range 1..65535");
  end
  if (MaxRetries < 1 || MaxRetries > 15) begin : g_bad_retries
    $error("MaxRetries out of range 1..15");
  end

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(RstHoldCycles - 1);
  localparam logic [CNT_W-1:0] AckLoad  = CNT_W'(AckTimeout - 1);

  state_e             state_q, state_d;
  logic               clr_first_q;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]   tmr_load_val, tmr_value;
  logic               timeout, retry_ok;
  logic [RETRY_W-1:0] retry_q;

  slv_guard_recovery_timer u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .enable   (tmr_en),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      clr_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_first_q <= (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
    end
  end

  // An ack arriving on the final timeout cycle still counts as success.
  assign timeout = (state_q == ST_WAIT_ACK) && tmr_zero && !bus.rst_stat_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (bus.rst_req_i) state_d = ST_ISOLATE;
      ST_ISOLATE:  state_d = ST_ASSERT;
      ST_ASSERT:   if (tmr_zero) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (bus.rst_stat_i)  state_d = ST_CLEAR;
        else if (tmr_zero)   state_d = retry_ok ? ST_ASSERT : ST_FAIL;
      end
      ST_CLEAR:    if (!bus.rst_req_i && bus.rst_stat_i) state_d = ST_IDLE;
      ST_FAIL:     state_d = ST_FAIL;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load     = (state_d != state_q) &&
                   ((state_d == ST_ASSERT) || (state_d == ST_WAIT_ACK));
    tmr_load_val = (state_d == ST_ASSERT) ? HoldLoad : AckLoad;
    tmr_en       = (state_q == ST_ASSERT) || (state_q == ST_WAIT_ACK);
  end

`ifdef SLV_GUARD_RECOVERY_RETRY_EN
  assign retry_ok = (retry_q < RETRY_W'(MaxRetries));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_q <= '0;
    end else if ((state_d == ST_ISOLATE) && (state_q != ST_ISOLATE)) begin
      retry_q <= '0;
    end else if (timeout && retry_ok) begin
      retry_q <= retry_q + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
  assign retry_q  = '0;
`endif

  // Guard enable passes through in IDLE and throughout reset.
  always_comb begin
    bus.guard_ena_o   = (rst_i || (state_q == ST_IDLE)) ? bus.guard_ena_i : 1'b0;
    bus.isolate_o     = (state_q != ST_IDLE);
    bus.slv_rst_o     = (state_q == ST_ASSERT);
    bus.reset_clear_o = (state_q == ST_CLEAR) && clr_first_q;
    bus.fail_o        = (state_q == ST_FAIL);
    bus.state_o       = state_q;
    bus.retry_cnt_o   = retry_q;
  end

endmodule

// File: tb/tb_slv_guard_recovery_ctrl.sv
// Directed scoreboard bench for slv_guard_recovery_ctrl (hold 4, timeout 8, retries 2).
module tb_slv_guard_recovery_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_ISO = 3'd1, S_ASSERT = 3'd2,
                         S_WAIT = 3'd3, S_CLEAR = 3'd4, S_FAIL = 3'd5;
  localparam int Hold = 4;
  localparam int Tmo  = 8;
`ifdef SLV_GUARD_RECOVERY_RETRY_EN
  localparam int NRounds = 3;
`else
  localparam int NRounds = 1;
`endif

  typedef struct {
    logic [2:0] st;
    logic       iso;
    logic       srst;
    logic       rc;
    logic       fail;
    logic [3:0] rty;
    logic       gena;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks   = 0;
  int    failures = 0;
  string phase    = "reset";
  exp_t  exp_q[$];

  slv_guard_recovery_if bus();

  slv_guard_recovery_ctrl #(
    .RstHoldCycles (Hold),
    .AckTimeout    (Tmo),
    .MaxRetries    (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s %s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // Push the expectation for the state after the next edge, then compare it.
  task automatic cyc(input logic [2:0] st, input logic rc, input logic [3:0] rty);
    exp_t e;
    exp_t g;
    e.st   = st;
    e.iso  = (st != S_IDLE);
    e.srst = (st == S_ASSERT);
    e.rc   = rc;
    e.fail = (st == S_FAIL);
    e.rty  = rty;
    e.gena = (st == S_IDLE) ? bus.guard_ena_i : 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("state",       {1'b0, bus.state_o},   {1'b0, g.st});
    chk("isolate",     {3'b0, bus.isolate_o}, {3'b0, g.iso});
    chk("slv_rst",     {3'b0, bus.slv_rst_o}, {3'b0, g.srst});
    chk("reset_clear", {3'b0, bus.reset_clear_o}, {3'b0, g.rc});
    chk("fail",        {3'b0, bus.fail_o},    {3'b0, g.fail});
    chk("retry_cnt",   bus.retry_cnt_o,       g.rty);
    chk("guard_ena",   {3'b0, bus.guard_ena_o}, {3'b0, g.gena});
  endtask

  initial begin
    rst             = 1'b1;
    bus.rst_req_i   = 1'b0;
    bus.rst_stat_i  = 1'b0;
    bus.guard_ena_i = 1'b1;
    cyc(S_IDLE, 1'b0, 4'd0);
    bus.guard_ena_i = 1'b0;
    cyc(S_IDLE, 1'b0, 4'd0);
    bus.guard_ena_i = 1'b1;
    rst = 1'b0;
    cyc(S_IDLE, 1'b0, 4'd0);

    phase = "nominal";
    bus.rst_req_i = 1'b1;
    cyc(S_ISO, 1'b0, 4'd0);
    for (int i = 0; i < Hold; i++) cyc(S_ASSERT, 1'b0, 4'd0);
    cyc(S_WAIT, 1'b0, 4'd0);
    cyc(S_WAIT, 1'b0, 4'd0);
    bus.rst_stat_i = 1'b1;
    cyc(S_CLEAR, 1'b1, 4'd0);
    cyc(S_CLEAR, 1'b0, 4'd0);
    bus.rst_req_i = 1'b0;
    cyc(S_IDLE, 1'b0, 4'd0);
    bus.rst_stat_i = 1'b0;
    cyc(S_IDLE, 1'b0, 4'd0);

    phase = "edge";
    bus.rst_req_i = 1'b1;
    cyc(S_ISO, 1'b0, 4'd0);
    bus.rst_req_i = 1'b0;
    for (int i = 0; i < Hold; i++) cyc(S_ASSERT, 1'b0, 4'd0);
    for (int i = 0; i < Tmo; i++) cyc(S_WAIT, 1'b0, 4'd0);
    bus.rst_stat_i = 1'b1;
    cyc(S_CLEAR, 1'b1, 4'd0);
    cyc(S_IDLE, 1'b0, 4'd0);
    bus.rst_stat_i = 1'b0;

    phase = "mid_assert_reset";
    bus.rst_req_i = 1'b1;
    cyc(S_ISO, 1'b0, 4'd0);
    bus.rst_req_i = 1'b0;
    cyc(S_ASSERT, 1'b0, 4'd0);
    cyc(S_ASSERT, 1'b0, 4'd0);
    rst = 1'b1;
    cyc(S_IDLE, 1'b0, 4'd0);
    rst = 1'b0;
    cyc(S_IDLE, 1'b0, 4'd0);

    phase = "timeout";
    bus.rst_req_i = 1'b1;
    cyc(S_ISO, 1'b0, 4'd0);
    bus.rst_req_i = 1'b0;
    for (int r = 0; r < NRounds; r++) begin
      for (int i = 0; i < Hold; i++) cyc(S_ASSERT, 1'b0, 4'(r));
      for (int i = 0; i < Tmo; i++) cyc(S_WAIT, 1'b0, 4'(r));
    end
    cyc(S_FAIL, 1'b0, 4'(NRounds - 1));
    bus.rst_req_i  = 1'b1;
    bus.rst_stat_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc(S_FAIL, 1'b0, 4'(NRounds - 1));
    bus.rst_req_i  = 1'b0;
    bus.rst_stat_i = 1'b0;

    phase = "fail_reset";
    rst = 1'b1;
    cyc(S_IDLE, 1'b0, 4'd0);
    rst = 1'b0;
    bus.guard_ena_i = 1'b0;
    cyc(S_IDLE, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
